pri_enc_if_sync: RTL and testbench

Registered priority encoder. It samples a request vector `Y` each clock and reports, one cycle later, the index of the highest-numbered asserted bit on `A`, plus a valid flag. The block is a generic arbitration/index front end: upstream logic drives raw request bits, and downstream logic consumes a clean, glitch-free registered index.

---
 rtl/pri_enc_if_sync.sv | 70 +++++++
 tb/tb_pri_enc_if_sync.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pri_enc_if_sync.sv
// pri_enc_if_sync: registered priority encoder, highest set bit of Y wins.
// Define PRI_ENC_IF_ONEHOT_EN to add the registered one-hot grant output G.
module pri_enc_if_sync #(
  parameter  int WIDTH = 4,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] Y,
  output logic [AW-1:0]    A,
`ifdef PRI_ENC_IF_ONEHOT_EN
  output logic             V,
  output logic [WIDTH-1:0] G
`else
  output logic             V
`endif
);

  logic [AW-1:0] w_idx;
  logic          w_any;
  logic [AW-1:0] r_a;
  logic          r_v;

  // Scan from the top bit down; the first set bit found wins.
  always_comb begin
    w_idx = '0;
    w_any = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!w_any && Y[i]) begin
        w_idx = AW'(i);
        w_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_v <= 1'b0;
    end else if (en) begin
      r_a <= w_idx;
      r_v <= w_any;
    end
  end

  assign A = r_a;
  assign V = r_v;

`ifdef PRI_ENC_IF_ONEHOT_EN
  logic [WIDTH-1:0] w_onehot;
  logic [WIDTH-1:0] r_g;

  always_comb begin
    w_onehot        = '0;
    w_onehot[w_idx] = w_any;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_g <= '0;
    end else if (en) begin
      r_g <= w_onehot;
    end
  end

  assign G = r_g;
`endif

endmodule

// File: tb/tb_pri_enc_if_sync.sv
// tb_pri_enc_if_sync: directed checks of the registered priority encoder.
// Covers sweep, async reset, hold, latency, one-hot grant and WIDTH=8.
module tb_pri_enc_if_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] Y;
  logic [1:0] A;
  logic       V;
  logic [7:0] Y8;
  logic [2:0] A8;
  logic       V8;
`ifdef PRI_ENC_IF_ONEHOT_EN
  logic [3:0] G;
  logic [7:0] G8;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pri_enc_if_sync #(.WIDTH(4)) u_dut (
    .clk(clk),
    .rst(rst),
    .en (en),
    .Y  (Y),
    .A  (A),
`ifdef PRI_ENC_IF_ONEHOT_EN
    .V  (V),
    .G  (G)
`else
    .V  (V)
`endif
  );

  pri_enc_if_sync #(.WIDTH(8)) u_dut8 (
    .clk(clk),
    .rst(rst),
    .en (en),
    .Y  (Y8),
    .A  (A8),
`ifdef PRI_ENC_IF_ONEHOT_EN
    .V  (V8),
    .G  (G8)
`else
    .V  (V8)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: search downward, stop at the first set bit.
  function automatic logic [2:0] ref_model(input logic [3:0] y);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (y[i]) begin
        r = {1'b1, 2'(i)};
        break;
      end
    end
    return r;
  endfunction

  initial begin
    logic [2:0] m;
    rst = 1'b1;
    en  = 1'b0;
    Y   = 4'b0000;
    Y8  = 8'h00;
    #12;
    check("reset_A", 32'(A), 32'd0);
    check("reset_V", 32'(V), 32'd0);
`ifdef PRI_ENC_IF_ONEHOT_EN
    check("reset_G", 32'(G), 32'd0);
`endif
    rst = 1'b0;
    en  = 1'b1;

    for (int y = 0; y < 16; y++) begin
      Y = 4'(y);
      tick();
      m = ref_model(4'(y));
      check($sformatf("sweep_A_%0d", y), 32'(A), 32'(m[1:0]));
      check($sformatf("sweep_V_%0d", y), 32'(V), 32'(m[2]));
`ifdef PRI_ENC_IF_ONEHOT_EN
      check($sformatf("sweep_G_%0d", y), 32'(G),
            m[2] ? (32'd1 << m[1:0]) : 32'd0);
`endif
    end
    check("sweep_last_A", 32'(A), 32'd3);

    Y = 4'b1000;
    tick();
    check("prerst_A", 32'(A), 32'd3);
    check("prerst_V", 32'(V), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_A", 32'(A), 32'd0);
    check("async_rst_V", 32'(V), 32'd0);
    #1 rst = 1'b0;
    Y = 4'b0100;
    tick();
    check("post_rst_A", 32'(A), 32'd2);
    check("post_rst_V", 32'(V), 32'd1);

    Y = 4'b0010;
    tick();
    check("hold_pre_A", 32'(A), 32'd1);
    en = 1'b0;
    Y  = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("hold_A_%0d", k), 32'(A), 32'd1);
      check($sformatf("hold_V_%0d", k), 32'(V), 32'd1);
    end
    en = 1'b1;
    tick();
    check("hold_release_A", 32'(A), 32'd3);

    for (int k = 0; k < 6; k++) begin
      Y = (k % 2 == 0) ? 4'b1000 : 4'b0001;
      tick();
      check($sformatf("lat_A_%0d", k), 32'(A),
            (k % 2 == 0) ? 32'd3 : 32'd0);
      check($sformatf("lat_V_%0d", k), 32'(V), 32'd1);
    end

`ifdef PRI_ENC_IF_ONEHOT_EN
    Y = 4'b1011;
    tick();
    check("onehot_1011", 32'(G), 32'h8);
    Y = 4'b0011;
    tick();
    check("onehot_0011", 32'(G), 32'h2);
    Y = 4'b0110;
    tick();
    check("onehot_0110", 32'(G), 32'h4);
    Y = 4'b0000;
    tick();
    check("onehot_0000", 32'(G), 32'h0);
`endif

    Y8 = 8'h01;
    tick();
    check("w8_01_A", 32'(A8), 32'd0);
    check("w8_01_V", 32'(V8), 32'd1);
    Y8 = 8'h90;
    tick();
    check("w8_90_A", 32'(A8), 32'd7);
    Y8 = 8'h3C;
    tick();
    check("w8_3C_A", 32'(A8), 32'd5);
    Y8 = 8'h00;
    tick();
    check("w8_00_V", 32'(V8), 32'd0);
    check("w8_00_A", 32'(A8), 32'd0);
`ifdef PRI_ENC_IF_ONEHOT_EN
    check("w8_00_G", 32'(G8), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
